enemy_ai: RTL and testbench

- Per-enemy behaviour controller directly upstream of the enemy movement block.
- Each frame it decides the enemy's movement direction and tracks hits taken. It emits the `dir` and `damage` controls the enemy block consumes.
- One instance per enemy slot (numbers 1-5). It observes the enemy's position, type and active flag, the player position, and the sword-hit pulse.

---
 rtl/enemy_ai.sv | 218 +++++++++++++++++++++
 tb/tb_enemy_ai.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_ai.sv
// Per-enemy behaviour controller: picks a movement direction each frame and tracks hits taken.
// Optional: define ENEMY_CHASE_EN to let type 2 (ReDead) chase the player when the player is nearby.
module enemy_ai #(
    parameter int unsigned HOLD_MIN    = 16,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter int unsigned CHASE_RANGE = 128,
    parameter int unsigned STUN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       initialize,
    input  logic       active,
    input  logic [1:0] Enemy_Type,
    input  logic [9:0] Enemy_X,
    input  logic [9:0] Enemy_Y,
    input  logic [9:0] Player_X,
    input  logic [9:0] Player_Y,
    input  logic       hit,
    output logic [2:0] dir,
    output logic       damage,
    output logic       stunned
);
    localparam int unsigned HOLD_W = 8;
    localparam int unsigned HP_W   = 2;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [2:0] DIR_NONE  = 3'd0;
    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_UP    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WANDER = 3'd1,
`ifdef ENEMY_CHASE_EN
        ST_CHASE  = 3'd2,
`endif
        ST_STUN   = 3'd3,
        ST_DEAD   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        dir_q, dir_d;
    logic              damage_q, damage_d;
    logic              stunned_q, stunned_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              vflag_q, vflag_d;
    logic              frame_q, frame_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              hit_latch_q, hit_latch_d;

    logic              tick_c;
    logic              hit_now;
    logic [15:0]       lfsr_nxt;
    logic              fighting;

    // Frame edge detect, LFSR advance and hit capture
    always_comb begin
        frame_d     = frame_clk;
        tick_c      = frame_clk & ~frame_q;
        lfsr_nxt    = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        lfsr_d      = tick_c ? lfsr_nxt : lfsr_q;
        hit_now     = hit_latch_q | hit;
        hit_latch_d = tick_c ? 1'b0 : hit_now;
    end

`ifdef ENEMY_CHASE_EN
    logic signed [10:0] dx, dy;
    logic [10:0]        adx, ady;
    logic [11:0]        dist;
    logic               in_range;
    logic [2:0]         chase_dir;

    // Direction toward the player along the dominant axis; ties go to X
    always_comb begin
        dx        = $signed({1'b0, Player_X}) - $signed({1'b0, Enemy_X});
        dy        = $signed({1'b0, Player_Y}) - $signed({1'b0, Enemy_Y});
        adx       = dx[10] ? 11'(-dx) : 11'(dx);
        ady       = dy[10] ? 11'(-dy) : 11'(dy);
        dist      = 12'(adx) + 12'(ady);
        in_range  = dist < 12'(CHASE_RANGE);
        chase_dir = DIR_NONE;
        if (adx >= ady) begin
            if (adx != 11'd0) chase_dir = dx[10] ? DIR_LEFT : DIR_RIGHT;
        end else begin
            chase_dir = dy[10] ? DIR_UP : DIR_DOWN;
        end
    end

    assign fighting = (state_q == ST_WANDER) || (state_q == ST_CHASE);
`else
    logic unused_chase_c;
    assign unused_chase_c = ^{Enemy_X, Enemy_Y, Player_X, Player_Y, 32'(CHASE_RANGE)};
    assign fighting = (state_q == ST_WANDER);
`endif

    // Behaviour FSM: everything moves only on a frame tick
    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        damage_d  = damage_q;
        stunned_d = stunned_q;
        hp_d      = hp_q;
        hold_d    = hold_q;
        vflag_d   = vflag_q;
        if (tick_c) begin
            if (initialize || (state_q != ST_IDLE && !active)) begin
                state_d   = ST_IDLE;
                dir_d     = DIR_NONE;
                damage_d  = 1'b0;
                stunned_d = 1'b0;
                hold_d    = '0;
                vflag_d   = 1'b0;
            end else if (fighting && hit_now) begin
                hp_d   = hp_q - HP_W'(1);
                dir_d  = DIR_NONE;
                hold_d = '0;
                if (hp_q <= HP_W'(1)) begin
                    state_d  = ST_DEAD;
                    damage_d = 1'b1;
                end else begin
                    state_d   = ST_STUN;
                    stunned_d = 1'b1;
                    hold_d    = HOLD_W'(STUN_FRAMES - 1);
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        dir_d = DIR_NONE;
                        if (active) begin
                            hp_d    = (Enemy_Type == 2'd2) ? HP_W'(2) : HP_W'(1);
                            state_d = ST_WANDER;
                            hold_d  = '0;
                            vflag_d = 1'b0;
                        end
                    end
                    ST_WANDER: begin
`ifdef ENEMY_CHASE_EN
                        if (Enemy_Type == 2'd2 && in_range) begin
                            state_d = ST_CHASE;
                            dir_d   = chase_dir;
                        end else
`endif
                        if (hold_q == '0) begin
                            hold_d = HOLD_W'(HOLD_MIN) + HOLD_W'(lfsr_nxt[5:2]);
                            if (Enemy_Type == 2'd3) begin
                                dir_d   = vflag_q ? DIR_UP : DIR_DOWN;
                                vflag_d = ~vflag_q;
                            end else begin
                                dir_d = 3'({1'b0, lfsr_nxt[1:0]}) + 3'd1;
                            end
                        end else begin
                            hold_d = hold_q - HOLD_W'(1);
                        end
                    end
`ifdef ENEMY_CHASE_EN
                    ST_CHASE: begin
                        if (!in_range) begin
                            state_d = ST_WANDER;
                            hold_d  = '0;
                        end else begin
                            dir_d = chase_dir;
                        end
                    end
`endif
                    ST_STUN: begin
                        dir_d = DIR_NONE;
                        if (hold_q == '0) begin
                            state_d   = ST_WANDER;
                            stunned_d = 1'b0;
                        end else begin
                            hold_d = hold_q - HOLD_W'(1);
                        end
                    end
                    ST_DEAD: begin
                        dir_d    = DIR_NONE;
                        damage_d = 1'b1;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_NONE;
            damage_q    <= 1'b0;
            stunned_q   <= 1'b0;
            hp_q        <= '0;
            hold_q      <= '0;
            vflag_q     <= 1'b0;
            frame_q     <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            hit_latch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            damage_q    <= damage_d;
            stunned_q   <= stunned_d;
            hp_q        <= hp_d;
            hold_q      <= hold_d;
            vflag_q     <= vflag_d;
            frame_q     <= frame_d;
            lfsr_q      <= lfsr_d;
            hit_latch_q <= hit_latch_d;
        end
    end

    assign dir     = dir_q;
    assign damage  = damage_q;
    assign stunned = stunned_q;

endmodule

// File: tb/tb_enemy_ai.sv
// Directed bench for enemy_ai: reset, wander picks, vertical slider, chase, stun, death, initialize.
module tb_enemy_ai;
    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       initialize;
    logic       active;
    logic [1:0] Enemy_Type;
    logic [9:0] Enemy_X, Enemy_Y, Player_X, Player_Y;
    logic       hit;
    logic [2:0] dir;
    logic       damage;
    logic       stunned;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_lfsr;
    int          m_hold;
    logic [2:0]  m_dir;
    logic        m_vflag;

    enemy_ai dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .initialize (initialize),
        .active     (active),
        .Enemy_Type (Enemy_Type),
        .Enemy_X    (Enemy_X),
        .Enemy_Y    (Enemy_Y),
        .Player_X   (Player_X),
        .Player_Y   (Player_Y),
        .hit        (hit),
        .dir        (dir),
        .damage     (damage),
        .stunned    (stunned)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [2:0] e_dir, input logic e_dmg, input logic e_stn);
        check({tag, "_dir"}, 16'(dir), 16'(e_dir));
        check({tag, "_damage"}, 16'(damage), 16'(e_dmg));
        check({tag, "_stunned"}, 16'(stunned), 16'(e_stn));
    endtask

    task automatic do_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        m_lfsr = lfsr_step(m_lfsr);
    endtask

    task automatic pulse_hit();
        @(negedge Clk) hit = 1'b1;
        @(negedge Clk) hit = 1'b0;
    endtask

    // Expected wander behaviour for one tick spent in the wander state
    task automatic wander_expect(input logic [1:0] typ);
        if (m_hold == 0) begin
            if (typ == 2'd3) begin
                m_dir   = m_vflag ? 3'd4 : 3'd3;
                m_vflag = ~m_vflag;
            end else begin
                m_dir = 3'({1'b0, m_lfsr[1:0]}) + 3'd1;
            end
            m_hold = 16 + int'(m_lfsr[5:2]);
        end else begin
            m_hold--;
        end
    endtask

    task automatic wander_run(input string tag, input logic [1:0] typ, input int n);
        for (int i = 0; i < n; i++) begin
            do_tick();
            wander_expect(typ);
            check(tag, 16'(dir), 16'(m_dir));
            if (typ == 2'd3) check({tag, "_vertical"}, 16'(dir == 3'd3 || dir == 3'd4), 16'(1));
        end
    endtask

    task automatic enter_wander(input logic [1:0] typ);
        Enemy_Type = typ;
        active     = 1'b1;
        do_tick();
        m_hold  = 0;
        m_vflag = 1'b0;
        m_dir   = 3'd0;
        check_out("enter", 3'd0, 1'b0, 1'b0);
    endtask

    task automatic deactivate();
        active = 1'b0;
        do_tick();
        check_out("deact", 3'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b1;
        frame_clk  = 1'($urandom);
        initialize = 1'($urandom);
        active     = 1'($urandom);
        Enemy_Type = 2'($urandom);
        Enemy_X    = 10'($urandom);
        Enemy_Y    = 10'($urandom);
        Player_X   = 10'($urandom);
        Player_Y   = 10'($urandom);
        hit        = 1'($urandom);
        #13 Reset = 1'b0;
        #1 check_out("reset", 3'd0, 1'b0, 1'b0);

        // Quiet inputs, release reset with the enemy inactive
        frame_clk  = 1'b0;
        initialize = 1'b0;
        active     = 1'b0;
        hit        = 1'b0;
        Enemy_Type = 2'd1;
        Enemy_X    = 10'd300;
        Enemy_Y    = 10'd200;
        Player_X   = 10'd0;
        Player_Y   = 10'd0;
        @(negedge Clk);
        @(negedge Clk);
        Reset  = 1'b1;
        m_lfsr = 16'hACE1;
        for (int i = 0; i < 100; i++) begin
            do_tick();
            check("idle_dir", 16'(dir), 16'(0));
        end

        // Keese: random wander with hold counter
        enter_wander(2'd1);
        wander_run("t1_wander", 2'd1, 40);
        deactivate();

        // Slider: vertical alternation 3,4,3
        enter_wander(2'd3);
        wander_run("t3_wander", 2'd3, 70);
        deactivate();

        // ReDead near the player
        Enemy_X  = 10'd300;
        Enemy_Y  = 10'd200;
        Player_X = 10'd340;
        Player_Y = 10'd220;
        enter_wander(2'd2);
`ifdef ENEMY_CHASE_EN
        do_tick();
        check_out("chase_right", 3'd2, 1'b0, 1'b0);
        Player_X = 10'd300;
        Player_Y = 10'd100;
        do_tick();
        check_out("chase_up", 3'd4, 1'b0, 1'b0);
        Player_X = 10'd0;
        Player_Y = 10'd0;
        do_tick();
        m_hold = 0;
        wander_run("chase_exit", 2'd2, 3);
`else
        wander_run("nochase_near", 2'd2, 1);
        Player_X = 10'd300;
        Player_Y = 10'd100;
        wander_run("nochase_mid", 2'd2, 1);
        Player_X = 10'd0;
        Player_Y = 10'd0;
        wander_run("nochase_far", 2'd2, 2);
`endif
        deactivate();

        // ReDead takes a hit, is stunned, ignores a second hit, then dies
        enter_wander(2'd2);
        wander_run("t2_pick", 2'd2, 1);
        pulse_hit();
        do_tick();
        check_out("stun_enter", 3'd0, 1'b0, 1'b1);
        pulse_hit();
        for (int i = 0; i < 29; i++) begin
            do_tick();
            check("stun_hold_stunned", 16'(stunned), 16'(1));
            check("stun_hold_dir", 16'(dir), 16'(0));
        end
        do_tick();
        check_out("stun_exit", 3'd0, 1'b0, 1'b0);
        m_hold = 0;
        m_dir  = 3'd0;
        wander_run("post_stun", 2'd2, 2);
        pulse_hit();
        do_tick();
        check_out("dead", 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("dead_hold", 16'(damage), 16'(1));
        end
        active = 1'b0;
        do_tick();
        check_out("dead_release", 3'd0, 1'b0, 1'b0);

        // Hit and initialize on the same tick; hp reloads on reactivation
        enter_wander(2'd2);
        wander_run("init_pick", 2'd2, 1);
        pulse_hit();
        do_tick();
        check_out("init_stun", 3'd0, 1'b0, 1'b1);
        initialize = 1'b1;
        pulse_hit();
        do_tick();
        initialize = 1'b0;
        check_out("init_idle", 3'd0, 1'b0, 1'b0);
        enter_wander(2'd2);
        wander_run("reload_pick", 2'd2, 1);
        pulse_hit();
        do_tick();
        check_out("reload_stun", 3'd0, 1'b0, 1'b1);

        // Asynchronous reset aborts mid-stun
        #2 Reset = 1'b0;
        #1 check_out("async_rst", 3'd0, 1'b0, 1'b0);
        #4 Reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
